// File: rtl/code_stream_pkg.sv
// Shared definitions for the code stream controller: FSM state encoding and
// default word / counter widths.
package code_stream_pkg;

  localparam int WORD_W_DEF = 16;
  localparam int CNT_W_DEF  = 5;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_SHIFT = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/code_shreg.sv
// Loadable MSB-first shift register feeding the serial output of the
// code stream controller.
module code_shreg
  import code_stream_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              load,
  input  logic              shift,
  input  logic [WORD_W-1:0] d,
  output logic              msb
);

  logic [WORD_W-1:0] sr_p0;

  // Load has priority over shift; shifting moves the next bit into the MSB.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sr_p0 <= '0;
    end else if (load) begin
      sr_p0 <= d;
    end else if (shift) begin
      sr_p0 <= {sr_p0[WORD_W-2:0], 1'b0};
    end
  end

  assign msb = sr_p0[WORD_W-1];

endmodule

// File: rtl/code_stream_ctrl.sv
// Serialises one word MSB-first into an external sequence detector and
// collects its match flag into hit / match_cnt / first_pos.
module code_stream_ctrl
  import code_stream_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [WORD_W-1:0] data_in,
  input  logic              Z,
  output logic              x,
  output logic              det_rst_n,
  output logic              busy,
  output logic              done,
  output logic              hit,
  output logic [CNT_W-1:0]  match_cnt,
  output logic [CNT_W-1:0]  first_pos
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           state;
  logic [CNT_W-1:0] bit_cnt;
  logic             det_clr_n;
  logic             sr_msb;
  logic             sr_load;
  logic             sr_shift;
  logic             z_eval;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  assign sr_load  = (state == S_IDLE) && start;
  // The first shift happens leaving CLR so x already carries bit 0 in SHIFT cycle 1.
  assign sr_shift = (state == S_CLR) || (state == S_SHIFT);
  // Z lags x by one cycle: the first SHIFT cycle sees the cleared detector,
  // DRAIN sees the result for the last bit.
  assign z_eval   = ((state == S_SHIFT) && (bit_cnt != '0)) || (state == S_DRAIN);
  // Detector is held in clear while the controller itself is in reset.
  assign det_rst_n = det_clr_n & ~RST;

  code_shreg #(.WORD_W(WORD_W)) u_shreg (
    .CLK   (CLK),
    .RST   (RST),
    .load  (sr_load),
    .shift (sr_shift),
    .d     (data_in),
    .msb   (sr_msb)
  );

  // Control FSM with registered outputs and match bookkeeping.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      x         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      hit       <= 1'b0;
      match_cnt <= '0;
      first_pos <= '0;
      det_clr_n <= 1'b1;
    end else begin
      done <= 1'b0;
      if (z_eval && Z) begin
        hit       <= 1'b1;
        match_cnt <= sat_inc(match_cnt);
        if (!hit) first_pos <= bit_cnt - CNT_W'(1);
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_CLR;
            bit_cnt   <= '0;
            hit       <= 1'b0;
            match_cnt <= '0;
            first_pos <= '0;
            busy      <= 1'b1;
            det_clr_n <= 1'b0;
          end
        end
        S_CLR: begin
          state     <= S_SHIFT;
          det_clr_n <= 1'b1;
          x         <= sr_msb;
        end
        S_SHIFT: begin
          bit_cnt <= bit_cnt + CNT_W'(1);
          if (bit_cnt == LAST_BIT) begin
            x     <= 1'b0;
            state <= S_DRAIN;
          end else begin
            x <= sr_msb;
          end
        end
        S_DRAIN: begin
          state <= S_DONE;
          busy  <= 1'b0;
        end
        S_DONE: begin
          // done is registered out of DONE, so it is seen in the following cycle.
          state <= S_IDLE;
          done  <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_code_stream_ctrl.sv
// Bench for code_stream_ctrl paired with a model of the external
// 1010100100111 sequence detector, in 16-bit and 32-bit configurations.
module tb_code_stream_ctrl;

  localparam logic [12:0] PAT = 13'b1010100100111;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        start16, z16 = 1'b0, x16, drn16, busy16, done16, hit16;
  logic [15:0] data16;
  logic [4:0]  cnt16, fp16;
  logic        start32, z32 = 1'b0, x32, drn32, busy32, done32, hit32;
  logic [31:0] data32;
  logic [5:0]  cnt32, fp32;
  logic [11:0] h16 = '0, h32 = '0;

  int passed = 0;
  int total  = 0;

  code_stream_ctrl #(.WORD_W(16), .CNT_W(5)) dut16 (
    .CLK(clk), .RST(rst), .start(start16), .data_in(data16), .Z(z16), .x(x16),
    .det_rst_n(drn16), .busy(busy16), .done(done16), .hit(hit16),
    .match_cnt(cnt16), .first_pos(fp16));

  code_stream_ctrl #(.WORD_W(32), .CNT_W(6)) dut32 (
    .CLK(clk), .RST(rst), .start(start32), .data_in(data32), .Z(z32), .x(x32),
    .det_rst_n(drn32), .busy(busy32), .done(done32), .hit(hit32),
    .match_cnt(cnt32), .first_pos(fp32));

  // External detector model: registered match of the last 13 serial bits.
  always @(posedge clk) begin
    if (!drn16) begin h16 <= '0; z16 <= 1'b0; end
    else begin h16 <= {h16[10:0], x16}; z16 <= ({h16, x16} == PAT); end
    if (!drn32) begin h32 <= '0; z32 <= 1'b0; end
    else begin h32 <= {h32[10:0], x32}; z32 <= ({h32, x32} == PAT); end
  end

  // Expected results: scan every 13-bit window of the word (bit 0 = MSB).
  task automatic ref_model(input logic [31:0] w, input int W, input int cw,
                           output bit h, output int c, output int f);
    h = 0; c = 0; f = 0;
    for (int e = 12; e < W; e++) begin
      bit m;
      m = 1;
      for (int k = 0; k < 13; k++)
        if (w[W-1-(e-12+k)] != PAT[12-k]) m = 0;
      if (m) begin
        if (!h) f = e;
        h = 1;
        if (c < (1 << cw) - 1) c++;
      end
    end
  endtask

  task automatic run16(input logic [15:0] d, input int rep_at, input logic [15:0] d2,
                       output int lat, output int lows);
    @(negedge clk);
    data16 = d; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    lows = (drn16 === 1'b0) ? 1 : 0;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (drn16 === 1'b0) lows++;
      if (lat == rep_at) begin start16 = 1'b1; data16 = d2; end
      else start16 = 1'b0;
      if (done16 === 1'b1) break;
    end
    start16 = 1'b0;
  endtask

  task automatic run32(input logic [31:0] d, output int lat, output int lows);
    @(negedge clk);
    data32 = d; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    lows = (drn32 === 1'b0) ? 1 : 0;
    lat = 0;
    while (lat < 60) begin
      @(posedge clk); #1;
      lat++;
      if (drn32 === 1'b0) lows++;
      if (done32 === 1'b1) break;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({busy16, done16, x16, hit16, cnt16, fp16} !== 14'd0)
      $display("FAIL reset16_outputs got %h want 0", {busy16, done16, x16, hit16, cnt16, fp16});
    else passed++;
    total++;
    if ({busy32, done32, x32, hit32, cnt32, fp32} !== 16'd0)
      $display("FAIL reset32_outputs got %h want 0", {busy32, done32, x32, hit32, cnt32, fp32});
    else passed++;
    total++;
    if (drn16 !== 1'b0) $display("FAIL reset_det_rst_n got %b want 0", drn16);
    else passed++;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if (drn16 !== 1'b1) $display("FAIL post_reset_det_rst_n got %b want 1", drn16);
    else passed++;
  endtask

  task automatic test_directed();
    logic [15:0] words [4] = '{16'hA938, 16'h549C, 16'h0000, 16'hFFFF};
    bit          eh [4]    = '{1, 1, 0, 0};
    int          ec [4]    = '{1, 1, 0, 0};
    int          ef [4]    = '{12, 13, 0, 0};
    int lat, lows;
    for (int i = 0; i < 4; i++) begin
      run16(words[i], -1, 16'h0, lat, lows);
      total++;
      if (lat !== 19) $display("FAIL dir_latency %h got %0d want 19", words[i], lat);
      else passed++;
      total++;
      if (lows !== 1) $display("FAIL dir_det_clr_cycles %h got %0d want 1", words[i], lows);
      else passed++;
      total++;
      if ({hit16, 27'(cnt16), 32'(fp16)} !== {eh[i], 27'(ec[i]), 32'(ef[i])})
        $display("FAIL dir_result %h got hit=%b cnt=%0d fp=%0d want hit=%b cnt=%0d fp=%0d",
                 words[i], hit16, cnt16, fp16, eh[i], ec[i], ef[i]);
      else passed++;
    end
  endtask

  task automatic test_start_ignored();
    int lat, lows;
    // re-start in the middle of SHIFT with another word
    run16(16'hA938, 6, 16'h549C, lat, lows);
    total++;
    if (lat !== 19) $display("FAIL ign_shift_latency got %0d want 19", lat);
    else passed++;
    total++;
    if ({hit16, cnt16, fp16} !== {1'b1, 5'd1, 5'd12})
      $display("FAIL ign_shift_result got hit=%b cnt=%0d fp=%0d want 1/1/12", hit16, cnt16, fp16);
    else passed++;
    // re-start while in DONE must not launch a new word
    run16(16'h549C, 18, 16'hA938, lat, lows);
    total++;
    if ({hit16, cnt16, fp16} !== {1'b1, 5'd1, 5'd13})
      $display("FAIL ign_done_result got hit=%b cnt=%0d fp=%0d want 1/1/13", hit16, cnt16, fp16);
    else passed++;
    repeat (4) @(posedge clk);
    #1;
    total++;
    if ({busy16, done16, hit16, cnt16, fp16} !== {1'b0, 1'b0, 1'b1, 5'd1, 5'd13})
      $display("FAIL hold_after_done got busy=%b done=%b hit=%b cnt=%0d fp=%0d want 0/0/1/1/13",
               busy16, done16, hit16, cnt16, fp16);
    else passed++;
  endtask

  task automatic test_reset_mid_shift();
    int lat, lows, seen;
    @(negedge clk);
    data16 = 16'hA938; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({busy16, done16, x16, hit16, cnt16, fp16, drn16} !== 15'd0)
      $display("FAIL mid_reset_outputs got %h want 0", {busy16, done16, x16, hit16, cnt16, fp16, drn16});
    else passed++;
    @(negedge clk); rst = 1'b0;
    seen = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done16 === 1'b1 || busy16 === 1'b1) seen++;
    end
    total++;
    if (seen !== 0) $display("FAIL mid_reset_no_done got %0d active cycles want 0", seen);
    else passed++;
    run16(16'hA938, -1, 16'h0, lat, lows);
    total++;
    if ({lat, 32'(fp16), hit16} !== {32'd19, 32'd12, 1'b1})
      $display("FAIL mid_reset_rerun got lat=%0d fp=%0d hit=%b want 19/12/1", lat, fp16, hit16);
    else passed++;
  endtask

  task automatic test_random();
    logic [15:0] w;
    bit eh; int ec, ef, lat, lows, o;
    for (int i = 0; i < 24; i++) begin
      w = 16'($urandom);
      if (i % 2 == 1) begin
        o = int'($urandom_range(0, 3));
        w[15-o -: 13] = PAT;
      end
      ref_model({16'h0, w}, 16, 5, eh, ec, ef);
      run16(w, -1, 16'h0, lat, lows);
      total++;
      if (lat !== 19) $display("FAIL rnd_latency %h got %0d want 19", w, lat);
      else passed++;
      total++;
      if ({hit16, 27'(cnt16), 32'(fp16)} !== {eh, 27'(ec), 32'(ef)})
        $display("FAIL rnd_result %h got hit=%b cnt=%0d fp=%0d want hit=%b cnt=%0d fp=%0d",
                 w, hit16, cnt16, fp16, eh, ec, ef);
      else passed++;
    end
  endtask

  task automatic test_word32();
    logic [31:0] words [3];
    bit eh; int ec, ef, lat, lows;
    words[0] = 32'hA9494E00;
    words[1] = $urandom;
    words[1][31-2 -: 13] = PAT;
    words[1][31-16 -: 13] = PAT;
    words[2] = $urandom;
    for (int i = 0; i < 3; i++) begin
      ref_model(words[i], 32, 6, eh, ec, ef);
      run32(words[i], lat, lows);
      total++;
      if (lat !== 35 || lows !== 1)
        $display("FAIL w32_timing %h got lat=%0d clr=%0d want 35/1", words[i], lat, lows);
      else passed++;
      total++;
      if ({hit32, 26'(cnt32), 32'(fp32)} !== {eh, 26'(ec), 32'(ef)})
        $display("FAIL w32_result %h got hit=%b cnt=%0d fp=%0d want hit=%b cnt=%0d fp=%0d",
                 words[i], hit32, cnt32, fp32, eh, ec, ef);
      else passed++;
    end
    total++;
    if ({cnt32, fp32} !== {6'd0, 6'd0} && words[2] == 32'hA9494E00)
      $display("FAIL w32_unreachable");
    else passed++;
  endtask

  initial begin
    rst = 1'b1;
    start16 = 1'b0; data16 = '0;
    start32 = 1'b0; data32 = '0;
    test_reset();
    test_directed();
    test_start_ignored();
    test_reset_mid_shift();
    test_random();
    test_word32();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
